// File: rtl/camera_config_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : camera_config_seq                                              |
// | Purpose  : Walks a register-initialisation ROM and replays each word as  |
// |            an SCCB register write. Supports delay markers, an end marker |
// |            and bounded retry on NACK.                                     |
// | Ports    : clk, rst_n (async, active low), start (level)                  |
// |            rom_addr/rom_data  - synchronous ROM, one cycle latency        |
// |            sccb_ready/sccb_err, sccb_start/sccb_addr/sccb_wdata - master  |
// |            busy, done, error, err_addr - status                           |
// | Options  : CAMCFG_READBACK_EN - every successful write is followed by a   |
// |            read of the same register (sccb_rd/sccb_rdata); a mismatch is  |
// |            treated like a NACK.                                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module camera_config_seq #(
    parameter int CLK_FREQ  = 25000000,
    parameter int ROM_AW    = 8,
    parameter int REG_AW    = 8,
    parameter int DELAY_MS  = 10,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [REG_AW+7:0] rom_data,
    input  logic              sccb_ready,
    input  logic              sccb_err,
    output logic              sccb_start,
    output logic [REG_AW-1:0] sccb_addr,
    output logic [7:0]        sccb_wdata,
`ifdef CAMCFG_READBACK_EN
    output logic              sccb_rd,
    input  logic [7:0]        sccb_rdata,
`endif
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_addr
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] DELAY     = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;
    localparam logic [2:0] FAIL      = 3'd7;

    localparam int C_DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
    localparam int C_TW        = (C_DELAY_CYC > 1) ? $clog2(C_DELAY_CYC) : 1;
    localparam int C_RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [C_TW-1:0]   C_DELAY_LOAD = C_TW'(C_DELAY_CYC - 1);
    localparam logic [C_RW-1:0]   C_MAX_RETRY  = C_RW'(MAX_RETRY);
    localparam logic [REG_AW+7:0] C_END_MARK   = '1;
    localparam logic [REG_AW+7:0] C_DLY_MARK   = {{(REG_AW + 4){1'b1}}, 4'h0};
    localparam logic [ROM_AW-1:0] C_LAST_ADDR  = '1;

    logic [2:0]      r_state;
    logic [C_TW-1:0] r_timer;
    logic [C_RW-1:0] r_retry;
    logic            w_resp_bad;

`ifdef CAMCFG_READBACK_EN
    // Set while the current attempt is the verifying read of a write that
    // just succeeded; a retry always restarts from the write.
    logic r_rd_phase;
    assign w_resp_bad = sccb_err || (r_rd_phase && (sccb_rdata != sccb_wdata));
`else
    assign w_resp_bad = sccb_err;
`endif

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_retry    <= '0;
            rom_addr   <= '0;
            sccb_start <= 1'b0;
            sccb_addr  <= '0;
            sccb_wdata <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
`ifdef CAMCFG_READBACK_EN
            r_rd_phase <= 1'b0;
            sccb_rd    <= 1'b0;
`endif
        end else begin
            sccb_start <= 1'b0;
`ifdef CAMCFG_READBACK_EN
            sccb_rd    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        r_retry  <= '0;
`ifdef CAMCFG_READBACK_EN
                        r_rd_phase <= 1'b0;
`endif
                        r_state  <= FETCH;
                    end
                end
                // ROM output for the new address is not valid until the next cycle.
                FETCH: r_state <= ISSUE;
                ISSUE: begin
                    if (rom_data == C_END_MARK) begin
                        r_state <= FINISH;
                    end else if (rom_addr == C_LAST_ADDR) begin
                        // Last ROM word is not an end marker: refuse to wrap.
                        err_addr <= rom_addr;
                        r_state  <= FAIL;
                    end else if (rom_data == C_DLY_MARK) begin
                        r_timer  <= C_DELAY_LOAD;
                        rom_addr <= rom_addr + 1'b1;
                        r_state  <= DELAY;
                    end else if (sccb_ready) begin
                        sccb_addr  <= rom_data[REG_AW+7:8];
                        sccb_wdata <= rom_data[7:0];
                        sccb_start <= 1'b1;
`ifdef CAMCFG_READBACK_EN
                        sccb_rd    <= r_rd_phase;
`endif
                        r_state    <= WAIT_ACK;
                    end
                end
                // The master needs a cycle to drop ready after accepting start.
                WAIT_ACK: begin
                    if (!sccb_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (sccb_ready) begin
                        if (!w_resp_bad) begin
`ifdef CAMCFG_READBACK_EN
                            if (!r_rd_phase) begin
                                r_rd_phase <= 1'b1;
                                r_state    <= ISSUE;
                            end else begin
                                r_rd_phase <= 1'b0;
                                r_retry    <= '0;
                                rom_addr   <= rom_addr + 1'b1;
                                r_state    <= FETCH;
                            end
`else
                            r_retry  <= '0;
                            rom_addr <= rom_addr + 1'b1;
                            r_state  <= FETCH;
`endif
                        end else if (r_retry < C_MAX_RETRY) begin
                            r_retry <= r_retry + 1'b1;
`ifdef CAMCFG_READBACK_EN
                            r_rd_phase <= 1'b0;
`endif
                            r_state <= ISSUE;
                        end else begin
                            err_addr <= rom_addr;
                            r_state  <= FAIL;
                        end
                    end
                end
                // Counts LOAD..0 inclusive, i.e. exactly C_DELAY_CYC cycles.
                DELAY: begin
                    if (r_timer == '0) begin
                        r_state <= FETCH;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                FAIL: begin
                    error   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_camera_config_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_camera_config_seq                                           |
// | Purpose  : Self-checking bench for camera_config_seq: synchronous ROM,   |
// |            SCCB slave with programmable NACKs, and a word-level model    |
// |            of the expected transaction list and final status.            |
// | Options  : CAMCFG_READBACK_EN - also exercises the readback path.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_camera_config_seq;

    localparam int CLK_FREQ  = 1000000;
    localparam int ROM_AW    = 4;
    localparam int REG_AW    = 8;
    localparam int DELAY_MS  = 10;
    localparam int MAX_RETRY = 3;
    localparam int DLY       = CLK_FREQ / 1000 * DELAY_MS;
    localparam int TMO       = 40000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sccb_ready = 1'b1;
    logic        sccb_err = 1'b0;
    logic [3:0]  rom_addr, err_addr;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sccb_start, busy, done, error;
    logic [7:0]  sccb_addr, sccb_wdata;
    logic        txn_rd;
`ifdef CAMCFG_READBACK_EN
    localparam bit RB = 1'b1;
    logic        sccb_rd;
    logic [7:0]  sccb_rdata = 8'h00;
    assign txn_rd = sccb_rd;
`else
    localparam bit RB = 1'b0;
    assign txn_rd = 1'b0;
`endif

    camera_config_seq #(
        .CLK_FREQ (CLK_FREQ),
        .ROM_AW   (ROM_AW),
        .REG_AW   (REG_AW),
        .DELAY_MS (DELAY_MS),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_ready(sccb_ready),
        .sccb_err  (sccb_err),
        .sccb_start(sccb_start),
        .sccb_addr (sccb_addr),
        .sccb_wdata(sccb_wdata),
`ifdef CAMCFG_READBACK_EN
        .sccb_rd   (sccb_rd),
        .sccb_rdata(sccb_rdata),
`endif
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    // ROM image and slave behaviour, owned by the stimulus block.
    logic [15:0] rom [16];
    int          nack_plan [256];   // NACKs per register; -1 = every attempt
    bit          corrupt [256];     // readback returns 0x00 for this register
    int          plan_gen = 0;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB slave: sees sccb_start on the falling edge, stays busy 1..3 cycles.
    int          slv_nack [256];
    int          seen_gen = 0;
    int          busy_cnt = 0;
    bit          pend_err = 1'b0;
    logic [7:0]  regmem [256];
    logic [16:0] log_q [$];          // {rd, reg addr, data}

    always @(negedge clk) begin
        if (seen_gen != plan_gen) begin
            slv_nack = nack_plan;
            seen_gen = plan_gen;
        end
        if (!rst_n) begin
            busy_cnt   = 0;
            sccb_ready = 1'b1;
            sccb_err   = 1'b0;
        end else if (sccb_start) begin
            log_q.push_back({txn_rd, sccb_addr, sccb_wdata});
            pend_err = 1'b0;
            if (slv_nack[sccb_addr] != 0) begin
                pend_err = 1'b1;
                if (slv_nack[sccb_addr] > 0) slv_nack[sccb_addr]--;
            end
`ifdef CAMCFG_READBACK_EN
            if (txn_rd) sccb_rdata = corrupt[sccb_addr] ? 8'h00 : regmem[sccb_addr];
`endif
            if (!txn_rd) regmem[sccb_addr] = sccb_wdata;
            sccb_ready = 1'b0;
            sccb_err   = 1'b0;
            busy_cnt   = $urandom_range(1, 3);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                sccb_ready = 1'b1;
                sccb_err   = pend_err;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level model: what the sequencer should do with the ROM image.
    logic [16:0] exp_q [$];
    bit          exp_done, exp_error;
    logic [3:0]  exp_eaddr;
    int          exp_delays;

    function automatic bit take(inout int n);
        if (n != 0) begin
            if (n > 0) n--;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model();
        int          nl [256];
        int          a;
        logic [15:0] w;
        bit          ok;
        nl = nack_plan;
        exp_q.delete();
        exp_done = 0; exp_error = 0; exp_eaddr = '0; exp_delays = 0;
        a = 0;
        forever begin
            w = rom[a];
            if (w == 16'hFFFF) begin exp_done = 1; return; end
            if (a == 15) begin exp_error = 1; exp_eaddr = 4'(a); return; end
            if (w == 16'hFFF0) begin exp_delays++; a++; continue; end
            ok = 0;
            for (int t = 0; t <= MAX_RETRY && !ok; t++) begin
                exp_q.push_back({1'b0, w});
                ok = take(nl[w[15:8]]);
                if (ok && RB) begin
                    exp_q.push_back({1'b1, w});
                    ok = take(nl[w[15:8]]) && (!corrupt[w[15:8]] || w[7:0] == 8'h00);
                end
            end
            if (!ok) begin exp_error = 1; exp_eaddr = 4'(a); return; end
            a++;
        end
    endtask

    task automatic clear_plan();
        for (int r = 0; r < 256; r++) begin
            nack_plan[r] = 0;
            corrupt[r]   = 0;
        end
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic wait_idle(output int cyc, input bit poke);
        cyc = 0;
        while (busy === 1'b1 && cyc < TMO) begin
            start = poke && (cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int base, input int cyc, input int mult);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/done"}, 32'(done), 32'(exp_done));
        check({tag, "/error"}, 32'(error), 32'(exp_error));
        if (exp_error) check({tag, "/err_addr"}, 32'(err_addr), 32'(exp_eaddr));
        check({tag, "/ntx"}, 32'(log_q.size() - base), 32'(mult * exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            check($sformatf("%s/tx%0d", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
        if (exp_delays > 0) begin
            check({tag, "/dly_min"}, 32'(cyc >= exp_delays * DLY), 32'd1);
            check({tag, "/dly_max"}, 32'(cyc <= exp_delays * DLY + 300), 32'd1);
        end
    endtask

    task automatic run(input string tag, input bit poke);
        int base, cyc;
        model();
        plan_gen++;
        repeat (2) @(negedge clk);
        base  = log_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cyc, poke);
        check_result(tag, base, cyc, 1);
    endtask

    initial begin
        int base, cyc, n, r;
        clear_plan();
        repeat (3) @(negedge clk);
        check("reset/outs", 32'({rom_addr, sccb_start, sccb_addr, sccb_wdata, busy, done, error, err_addr}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two plain writes then end marker.
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        run("basic", 1'b0);

        // First command NACKed twice, then accepted.
        nack_plan[8'h12] = 2;
        run("nack2", 1'b0);

        // Third command NACKed on every attempt.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1305; rom[3] = 16'hFFFF;
        nack_plan[8'h13] = -1;
        run("fail", 1'b0);

        // Reset while a transaction is outstanding.
        clear_plan();
        rom[0] = 16'h2A11; rom[1] = 16'h2B22; rom[2] = 16'h2C33; rom[3] = 16'hFFFF;
        plan_gen++;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (sccb_ready === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        check("rst/slave_busy", 32'(sccb_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst/outs", 32'({rom_addr, sccb_start, sccb_addr, sccb_wdata, busy, done, error, err_addr}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst/stays_idle", 32'(busy), 32'd0);
        run("replay", 1'b0);

        // Single delay marker, then two consecutive ones.
        clear_plan();
        rom[0] = 16'hFFF0; rom[1] = 16'hFFFF;
        run("delay1", 1'b0);
        rom[0] = 16'hFFF0; rom[1] = 16'hFFF0; rom[2] = 16'h3C5A; rom[3] = 16'hFFFF;
        run("delay2", 1'b0);

        // ROM runs out without an end marker.
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom_range(0, 16'hFFEF));
        run("overflow", 1'b0);

        // start held high restarts right after FINISH.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        model();
        plan_gen++;
        repeat (2) @(negedge clk);
        base  = log_q.size();
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < TMO) begin @(negedge clk); cyc++; end
        check("hold/done1", 32'(done), 32'd1);
        @(negedge clk);
        check("hold/restart", 32'({busy, done}), 32'b10);
        start = 1'b0;
        wait_idle(cyc, 1'b0);
        check_result("hold", base, cyc, 2);

        // Random ROM images with random NACK counts; start poked mid-run.
        for (int k = 0; k < 4; k++) begin
            clear_plan();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) rom[i] = 16'($urandom_range(0, 16'hFFEF));
            rom[n] = 16'hFFFF;
            r = $urandom_range(0, n - 1);
            nack_plan[rom[r][15:8]] = $urandom_range(0, MAX_RETRY + 1);
            run($sformatf("rand%0d", k), k[0]);
        end

`ifdef CAMCFG_READBACK_EN
        // Slave reads back 0x00 for a write of 0x80.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        corrupt[8'h12] = 1;
        run("readback", 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_config_seq.md
CAMERA_CONFIG_SEQ -- requirements
Module: camera_config_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, clock frequency in Hz, used for delay timing.
REQ-002 SHALL have parameter ROM_AW, default 8, ROM address width.
REQ-003 SHALL have parameter REG_AW, default 8, sensor register address width (8 or 16).
REQ-004 SHALL have parameter DELAY_MS, default 10, delay length for a delay marker, in ms.
REQ-005 SHALL have parameter MAX_RETRY, default 3, retries per command after an SCCB error.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, level; begins a sequence when sampled high in IDLE.
REQ-009 SHALL have port rom_addr, output, ROM_AW, ROM word address.
REQ-010 SHALL have port rom_data, input, REG_AW+8, ROM word; valid one cycle after rom_addr changes.
REQ-011 SHALL have port sccb_ready, input, 1, SCCB master is idle.
REQ-012 SHALL have port sccb_err, input, 1, NACK flag, valid in the cycle sccb_ready returns high.
REQ-013 SHALL have port sccb_start, output, 1, one-cycle transaction request.
REQ-014 SHALL have port sccb_addr, output, REG_AW, register address.
REQ-015 SHALL have port sccb_wdata, output, 8, write data.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-017 SHALL have port done, output, 1, sticky success flag.
REQ-018 SHALL have port error, output, 1, sticky failure flag.
REQ-019 SHALL have port err_addr, output, ROM_AW, ROM address of the failing command.

Function
REQ-020 SHALL use states IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, FINISH, FAIL.
REQ-021 IDLE with start=1 SHALL: clear rom_addr, done, error and the retry counter; go to FETCH.
REQ-022 FETCH SHALL last exactly one cycle, to cover ROM latency; then go to ISSUE.
REQ-023 ISSUE SHALL decode rom_data; all-ones is the end marker and goes to FINISH with no SCCB transaction.
REQ-024 ISSUE SHALL treat all-ones minus 0xF (e.g. 0xFFF0 when REG_AW=8) as a delay marker: load CLK_FREQ/1000*DELAY_MS-1, increment rom_addr, go to DELAY.
REQ-025 For any other word, ISSUE SHALL wait for sccb_ready=1, then drive sccb_addr=rom_data[REG_AW+7:8] and sccb_wdata=rom_data[7:0], pulse sccb_start for exactly one cycle, and go to WAIT_ACK.
REQ-026 WAIT_ACK SHALL wait for sccb_ready=0, then go to WAIT_DONE; no new sccb_start is allowed meanwhile.
REQ-027 WAIT_DONE on sccb_ready=1 with sccb_err=0 SHALL clear the retry counter, increment rom_addr, and go to FETCH.
REQ-028 WAIT_DONE on sccb_ready=1 with sccb_err=1 SHALL, if retries < MAX_RETRY, increment retries and return to ISSUE at the same rom_addr.
REQ-029 WAIT_DONE on sccb_ready=1 with sccb_err=1 SHALL, if retries = MAX_RETRY, set err_addr=rom_addr and go to FAIL.
REQ-030 DELAY SHALL count down to 0 inclusive, then go to FETCH; the delay lasts exactly CLK_FREQ/1000*DELAY_MS cycles.
REQ-031 Consecutive delay markers SHALL each produce a full delay.
REQ-032 FINISH SHALL set done=1 and go to IDLE; FAIL SHALL set error=1 and go to IDLE.
REQ-033 If rom_addr reaches its all-ones value without an end marker, it SHALL not wrap; the sequencer SHALL set err_addr to that value and go to FAIL.
REQ-034 start asserted while busy=1 SHALL be ignored.
REQ-035 start held high SHALL restart the sequence from IDLE on the cycle after FINISH or FAIL.

Reset
REQ-036 rst_n=0 SHALL asynchronously force state IDLE, and force to 0: rom_addr, sccb_start, sccb_addr, sccb_wdata, busy, done, error, err_addr, timer, and the retry counter.
REQ-037 Reset mid-transaction SHALL abandon the sequence; after release the block waits in IDLE for start.

Configuration
REQ-038 With macro CAMCFG_READBACK_EN defined, each successful write SHALL be followed by a read of the same register.
REQ-039 Under CAMCFG_READBACK_EN, the read SHALL use an added output sccb_rd (high with sccb_start) and an added input sccb_rdata, valid with sccb_ready.
REQ-040 Under CAMCFG_READBACK_EN, a readback mismatch SHALL be handled as an sccb_err (retry, then FAIL).
REQ-041 Without CAMCFG_READBACK_EN, sccb_rd and sccb_rdata SHALL not exist, and no read is issued.

Verification
REQ-042 ROM {0x1280, 0x1101, 0xFFFF}, ideal slave -> two sccb_start pulses with addr/data 0x12/0x80 then 0x11/0x01; done=1; error=0.
REQ-043 ROM {0xFFF0, 0xFFFF}, CLK_FREQ=1000000, DELAY_MS=10 -> done asserts at least 10000 cycles after start; no sccb_start.
REQ-044 First command NACKed twice, MAX_RETRY=3 -> three sccb_start pulses for the same word; then done=1.
REQ-045 Command at address 2 NACKed on every attempt -> four attempts; error=1; err_addr=2; done=0.
REQ-046 rst_n pulsed low during WAIT_DONE -> all outputs 0 immediately; the next start replays from address 0.
REQ-047 CAMCFG_READBACK_EN defined, slave returns 0x00 for a write of 0x80 -> retries, then error=1.
